// File: rtl/flash_adc_pkg.sv
// rtl/flash_adc_pkg.sv - shared helpers for the flash ADC thermometer encoder
// Bubble correction and ones-count work on a MAX_M-wide word; callers pass the live comparator count.
package flash_adc_pkg;

  localparam int MAX_M = 255;

  function automatic int M_OF(input int nbits);
    return (1 << nbits) - 1;
  endfunction

  function automatic int ACC_W(input int nbits, input int avg_log);
    return nbits + avg_log;
  endfunction

  // Three-tap majority vote; below bit 0 reads as 1 and above bit m-1 reads as 0.
  function automatic logic [MAX_M-1:0] therm_majority_fix(input logic [MAX_M-1:0] t, input int m);
    logic [MAX_M-1:0] c;
    logic lo;
    logic hi;
    c  = '0;
    lo = 1'b0;
    hi = 1'b0;
    for (int i = 0; i < MAX_M; i++) begin
      if (i < m) begin
        lo   = (i == 0) ? 1'b1 : t[i-1];
        hi   = (i == m - 1) ? 1'b0 : t[i+1];
        c[i] = (lo & t[i]) | (lo & hi) | (t[i] & hi);
      end
    end
    return c;
  endfunction

  function automatic int popcount(input logic [MAX_M-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_M; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/flash_avg_accum.sv
// rtl/flash_avg_accum.sv - block averager over 2^AVG_LOG encoded samples
// AVG_LOG=0 degenerates to a one-cycle delay of the code stream.
module flash_avg_accum
  import flash_adc_pkg::*;
#(
  parameter int NBITS   = 3,
  parameter int AVG_LOG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             avg_clr_i,
  input  logic             code_valid_i,
  input  logic [NBITS-1:0] code_i,
  output logic [NBITS-1:0] avg_out_o,
  output logic             avg_valid_o
);

  logic [NBITS-1:0] avg_q, avg_d;
  logic             av_q, av_d;

  generate
    if (AVG_LOG == 0) begin : g_passthru
      always_comb begin
        avg_d = avg_q;
        av_d  = code_valid_i;
        if (code_valid_i) avg_d = code_i;
      end
    end else begin : g_block
      localparam int AW = ACC_W(NBITS, AVG_LOG);
      logic [AW-1:0]      acc_q, acc_d, sum;
      logic [AVG_LOG-1:0] cnt_q, cnt_d;

      // Clear takes priority over a coincident sample, which is then dropped.
      always_comb begin
        sum   = acc_q + AW'(code_i);
        acc_d = acc_q;
        cnt_d = cnt_q;
        avg_d = avg_q;
        av_d  = 1'b0;
        if (avg_clr_i) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (code_valid_i) begin
          if (cnt_q == {AVG_LOG{1'b1}}) begin
            avg_d = NBITS'(sum >> AVG_LOG);
            av_d  = 1'b1;
            acc_d = '0;
            cnt_d = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_q <= '0;
      av_q  <= 1'b0;
    end else begin
      avg_q <= avg_d;
      av_q  <= av_d;
    end
  end

  assign avg_out_o   = avg_q;
  assign avg_valid_o = av_q;

endmodule

// File: rtl/flash_therm_encoder.sv
// rtl/flash_therm_encoder.sv - flash ADC thermometer-to-binary encoder with bubble fix and averaging
// Define FLASH_ENC_ERR_CNT_EN to build the saturating bubble-event counter on err_cnt.
module flash_therm_encoder
  import flash_adc_pkg::*;
#(
  parameter int NBITS   = 3,
  parameter int AVG_LOG = 2,
  parameter int ERR_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_en,
  input  logic [M_OF(NBITS)-1:0]    therm_in,
  input  logic                      avg_clr,
  output logic [NBITS-1:0]          code_out,
  output logic                      code_valid,
  output logic                      bubble_flag,
  output logic [NBITS-1:0]          avg_out,
  output logic                      avg_valid,
  output logic [ERR_W-1:0]          err_cnt
);

  localparam int M = M_OF(NBITS);

  logic [M-1:0]     t_q, t_d;
  logic             v1_q, v1_d;
  logic [NBITS-1:0] code_q, code_d;
  logic             bubble_q, bubble_d;
  logic             valid_q, valid_d;
  logic [MAX_M-1:0] fixed;

  assign fixed = therm_majority_fix(MAX_M'(t_q), M);

  always_comb begin
    t_d      = sample_en ? therm_in : t_q;
    v1_d     = sample_en;
    code_d   = code_q;
    bubble_d = bubble_q;
    valid_d  = v1_q;
    if (v1_q) begin
      code_d   = NBITS'(popcount(fixed));
      bubble_d = (fixed[M-1:0] != t_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q      <= '0;
      v1_q     <= 1'b0;
      code_q   <= '0;
      bubble_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      t_q      <= t_d;
      v1_q     <= v1_d;
      code_q   <= code_d;
      bubble_q <= bubble_d;
      valid_q  <= valid_d;
    end
  end

  assign code_out    = code_q;
  assign code_valid  = valid_q;
  assign bubble_flag = bubble_q;

  flash_avg_accum #(
    .NBITS   (NBITS),
    .AVG_LOG (AVG_LOG)
  ) u_avg (
    .clk          (clk),
    .rst_n        (rst_n),
    .avg_clr_i    (avg_clr),
    .code_valid_i (valid_q),
    .code_i       (code_q),
    .avg_out_o    (avg_out),
    .avg_valid_o  (avg_valid)
  );

`ifdef FLASH_ENC_ERR_CNT_EN
  logic [ERR_W-1:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (valid_q && bubble_q && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_flash_therm_encoder.sv
// tb/tb_flash_therm_encoder.sv - scoreboard bench for flash_therm_encoder (NBITS=3, AVG_LOG=2, ERR_W=8)
module tb_flash_therm_encoder;

  localparam int NBITS   = 3;
  localparam int AVG_LOG = 2;
  localparam int ERR_W   = 8;
  localparam int M       = 7;
  localparam int BLK     = 4;
  localparam int ERR_MAX = 255;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_en = 1'b0;
  logic [M-1:0]     therm_in = '0;
  logic             avg_clr = 1'b0;
  logic [NBITS-1:0] code_out;
  logic             code_valid;
  logic             bubble_flag;
  logic [NBITS-1:0] avg_out;
  logic             avg_valid;
  logic [ERR_W-1:0] err_cnt;

  flash_therm_encoder #(
    .NBITS   (NBITS),
    .AVG_LOG (AVG_LOG),
    .ERR_W   (ERR_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .therm_in    (therm_in),
    .avg_clr     (avg_clr),
    .code_out    (code_out),
    .code_valid  (code_valid),
    .bubble_flag (bubble_flag),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int bubble;
    int due;
  } exp_t;

  exp_t code_exp[$];
  exp_t avg_pend[$];
  exp_t avg_exp[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   blk_n = 0;
  int   blk_sum = 0;
  int   exp_err = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: extend with a 1 below and 0 above, vote each bit over its neighbourhood, count ones.
  function automatic void ref_encode(input logic [M-1:0] t, output int code, output int bubble);
    int ext[M+2];
    int c;
    ext[0]   = 1;
    ext[M+1] = 0;
    for (int i = 0; i < M; i++) ext[i+1] = int'(t[i]);
    code   = 0;
    bubble = 0;
    for (int i = 0; i < M; i++) begin
      c = ((ext[i] + ext[i+1] + ext[i+2]) >= 2) ? 1 : 0;
      code += c;
      if (c != int'(t[i])) bubble = 1;
    end
  endfunction

  function automatic logic [M-1:0] rand_therm();
    logic [M-1:0] v;
    int k;
    int idx;
    k = $urandom_range(0, M);
    v = M'((1 << k) - 1);
    if ($urandom_range(0, 3) == 0) begin
      idx    = $urandom_range(0, M - 1);
      v[idx] = ~v[idx];
    end
    return v;
  endfunction

  initial begin : model
    exp_t e;
    int   c;
    int   b;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        code_exp.delete();
        avg_pend.delete();
        avg_exp.delete();
        blk_n   = 0;
        blk_sum = 0;
        exp_err = 0;
      end else begin
        cyc++;
        if (avg_pend.size() > 0 && avg_pend[0].due == cyc) begin
          e = avg_pend.pop_front();
          if (e.bubble != 0 && exp_err < ERR_MAX) exp_err++;
          if (avg_clr) begin
            blk_n   = 0;
            blk_sum = 0;
          end else begin
            blk_sum += e.code;
            blk_n++;
            if (blk_n == BLK) begin
              avg_exp.push_back('{blk_sum / BLK, 0, cyc});
              blk_n   = 0;
              blk_sum = 0;
            end
          end
        end else if (avg_clr) begin
          blk_n   = 0;
          blk_sum = 0;
        end
        if (sample_en) begin
          ref_encode(therm_in, c, b);
          code_exp.push_back('{c, b, cyc + 1});
          avg_pend.push_back('{c, b, cyc + 2});
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (code_valid) begin
        if (code_exp.size() == 0) begin
          check("code_valid_unexpected", code_exp.size(), 1);
        end else begin
          e = code_exp.pop_front();
          check("code_valid_cycle", cyc, e.due);
          check("code_out", int'(code_out), e.code);
          check("bubble_flag", int'(bubble_flag), e.bubble);
        end
      end
      if (avg_valid) begin
        if (avg_exp.size() == 0) begin
          check("avg_valid_unexpected", avg_exp.size(), 1);
        end else begin
          e = avg_exp.pop_front();
          check("avg_valid_cycle", cyc, e.due);
          check("avg_out", int'(avg_out), e.code);
        end
      end
`ifdef FLASH_ENC_ERR_CNT_EN
      check("err_cnt", int'(err_cnt), exp_err);
`else
      check("err_cnt_zero", int'(err_cnt), 0);
`endif
    end
  end

  task automatic drive(input logic sen, input logic [M-1:0] t, input logic clr);
    @(negedge clk);
    sample_en = sen;
    therm_in  = t;
    avg_clr   = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_code_out"}, int'(code_out), 0);
    check({tag, "_code_valid"}, int'(code_valid), 0);
    check({tag, "_bubble_flag"}, int'(bubble_flag), 0);
    check({tag, "_avg_out"}, int'(avg_out), 0);
    check({tag, "_avg_valid"}, int'(avg_valid), 0);
    check({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  initial begin : stim
    logic [M-1:0] singles[4];
    logic [M-1:0] b2b[4];
    singles = '{7'b0000000, 7'b0000111, 7'b1111111, 7'b0001011};
    b2b     = '{7'b0000001, 7'b0000011, 7'b0000111, 7'b0011111};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (singles[i]) begin
      drive(1'b1, singles[i], 1'b0);
      idle(3);
    end

    foreach (b2b[i]) drive(1'b1, b2b[i], 1'b0);
    idle(4);

    // Clear lands on the 2nd sample's code_valid cycle.
    for (int i = 0; i < 6; i++) drive(1'b1, rand_therm(), (i == 3));
    idle(4);

    drive(1'b1, 7'b0000011, 1'b0);
    drive(1'b1, 7'b0001111, 1'b0);
    idle(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, rand_therm(), 1'b0);
    idle(4);

    repeat (400) drive(($urandom_range(0, 9) < 7), rand_therm(), ($urandom_range(0, 19) == 0));
    idle(5);

    repeat (300) drive(1'b1, 7'b0001011, 1'b0);
    idle(5);
`ifdef FLASH_ENC_ERR_CNT_EN
    check("err_cnt_saturated", int'(err_cnt), ERR_MAX);
`else
    check("err_cnt_disabled", int'(err_cnt), 0);
`endif

    idle(10);
    check("code_queue_drained", code_exp.size(), 0);
    check("avg_queue_drained", avg_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_therm_encoder.md
Name: flash_therm_encoder

Overview:
- Parametrised thermometer-to-binary encoder for an NBITS flash ADC; next generation of the 2-bit comparator encoder.
- Sits between the comparator bank and the digital back-end.
- Registers the comparator word on a sample strobe, removes single-bit bubbles, and encodes by ones-count.
- Produces a registered binary code plus a block-averaged code over 2^AVG_LOG samples.

Parameters:
- NBITS, 3, output code width; comparator count M = 2^NBITS-1.
- AVG_LOG, 2, log2 of averaging block length; 0 = no averaging (avg_out follows code_out).
- ERR_W, 8, width of the bubble-error counter (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sample_en  in  1  capture strobe; therm_in is sampled on a clk edge where sample_en=1.
- therm_in  in  M  comparator outputs; bit 0 = lowest threshold.
- avg_clr  in  1  synchronous clear of the averaging accumulator and counter.
- code_out  out  NBITS  encoded code of the latest sample.
- code_valid  out  1  one-cycle pulse: code_out updated.
- bubble_flag  out  1  qualified by code_valid; 1 when bubble correction changed any bit.
- avg_out  out  NBITS  block average.
- avg_valid  out  1  one-cycle pulse: avg_out updated.
- err_cnt  out  ERR_W  saturating bubble-event count; tied 0 without ERR_CNT_EN.

Behaviour:
- Reset (rst_n=0, asynchronous): all pipeline registers, code_out, code_valid, bubble_flag, avg_out, avg_valid, accumulator, block counter and err_cnt go to 0.
- Stage 1, edge k with sample_en=1:
  - t_reg <= therm_in, v1 <= 1.
  - sample_en=0 sets v1 <= 0; t_reg holds.
- Stage 2, edge k+1, when v1=1:
  - Correction: c[i] = majority(t[i-1], t[i], t[i+1]), with virtual t[-1]=1 and t[M]=0.
  - code_out <= popcount(c), range 0..M.
  - bubble_flag <= (c != t_reg).
  - code_valid <= 1; otherwise code_valid <= 0.
  - code_out and bubble_flag hold their values between pulses.
- Latency: code_valid is high in the cycle after edge k+1. Throughput is one sample per clock; back-to-back sample_en is legal.
- Averaging, AVG_LOG>0:
  - Accumulator width is NBITS+AVG_LOG; the block counter has AVG_LOG bits.
  - On each code_valid cycle, acc += code_out and cnt += 1.
  - When cnt = 2^AVG_LOG-1 on a code_valid cycle, the next edge sets avg_out <= (acc+code_out) >> AVG_LOG (truncating) and avg_valid <= 1, and clears acc and cnt.
  - The accumulator cannot overflow by construction.
- Averaging, AVG_LOG=0: avg_out <= code_out and avg_valid <= code_valid, one clock after code_valid.
- avg_clr=1:
  - Next edge clears acc and cnt.
  - If avg_clr coincides with a code_valid cycle, clear wins and that sample is excluded from the average; avg_valid is not raised.
  - code_out path is unaffected.
- All-zero input gives code 0; all-one input gives code M. Multi-bit bubbles are not fully corrected, but the ones-count keeps the output monotonic-safe and in range.
- Reset asserted mid-block discards the partial average. The first avg_valid after reset needs a full 2^AVG_LOG samples.

Optional Feature:
- Macro: FLASH_ENC_ERR_CNT_EN.
- Defined: err_cnt increments by 1 on each code_valid cycle with bubble_flag=1, saturates at 2^ERR_W-1, and is cleared only by reset.
- Undefined: no counter logic is built; err_cnt is constant 0.

Decomposition:
- Shared package flash_adc_pkg holds:
  - function therm_majority_fix (bubble correction);
  - function popcount;
  - localparam helpers M_OF(NBITS) and ACC_W.
- One natural sub-module, flash_avg_accum: accumulator, counter and avg_out/avg_valid logic, parametrised by NBITS and AVG_LOG.

Test Plan (NBITS=3, AVG_LOG=2, ERR_W=8):
- Single strobes with therm_in = 0000000, 0000111, 1111111 -> code_out = 0, 3, 7; each code_valid pulses exactly 2 edges after its strobe; bubble_flag=0.
- therm_in = 0001011 -> corrected 0000111, code_out=3, bubble_flag=1; with the macro defined, err_cnt=1.
- Back-to-back strobes giving codes 1, 2, 3, 5 -> exactly one avg_valid, after the 4th code_valid, with avg_out=2 (11>>2).
- avg_clr asserted on the same cycle as the 2nd code_valid of a block -> that sample is dropped; avg_valid appears only after 4 further samples.
- rst_n pulsed low asynchronously mid-block (after 2 samples) -> all outputs 0 immediately; the next avg_valid requires 4 new samples.
- With the macro defined, 300 bubble samples -> err_cnt saturates at 255. Without the macro -> err_cnt stays 0.
